// File: rtl/pwm_pkg.sv
// Shared PWM definitions: measurement FSM states and default sizing
// constants common to the binary-weighted PWM generator and decoder.
package pwm_pkg;

  localparam int PWM_DUTY_W  = 8;      // duty resolution (bits)
  localparam int PWM_CNT_W   = 16;     // period / high-time counter width
  localparam int PWM_TIMEOUT = 65535;  // clocks without a rise before STUCK

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    MEAS  = 2'd2,
    STUCK = 2'd3
  } pwm_state_e;

endpackage

// File: rtl/pwm_frac_div.sv
// Restoring fractional divider: q = floor(h * 2^DUTY_W / p), assuming h < p.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        load h/p and begin (ignored while abort is high)
//   abort        drop any division in flight, no done
//   h, p         dividend (high time) and divisor (period)
//   busy         high from the cycle after start through the done cycle
//   done         one-cycle pulse; q is final while it is high
//   q            quotient
// One load cycle, then DUTY_W iterations; done is raised with the last
// iteration and busy drops on the following edge.
module pwm_frac_div #(
  parameter int DUTY_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  h,
  input  logic [CNT_W-1:0]  p,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] q
);

  localparam int IW = $clog2(DUTY_W + 1);

  logic [CNT_W:0]   r;
  logic [CNT_W:0]   r2;
  logic [CNT_W-1:0] dvs;
  logic [IW-1:0]    it;
  logic             ge;

  // remainder stays below p, so the doubled value always fits CNT_W+1 bits
  assign r2 = r << 1;
  assign ge = (r2 >= {1'b0, dvs});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r    <= '0;
      dvs  <= '0;
      q    <= '0;
      it   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      r    <= {1'b0, h};
      dvs  <= p;
      q    <= '0;
      it   <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (done) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (busy) begin
      r  <= ge ? (r2 - {1'b0, dvs}) : r2;
      q  <= {q[DUTY_W-2:0], ge};
      it <= it + IW'(1);
      if (it == IW'(DUTY_W - 1)) done <= 1'b1;
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM receiver / duty-cycle measurer.
// Samples an asynchronous PWM line, measures period P and high time H in
// clocks between consecutive rising edges and reports
// duty = floor(H * 2^DUTY_W / P). Flags stuck lines and over-fast inputs.
// Ports:
//   clk, rst_n    clock, async active-low reset (clears synchronizer too)
//   ena           block enable; low forces IDLE
//   pwm_in        asynchronous PWM line
//   duty_o        last duty result, held between updates
//   period_o      last measured period
//   valid_o       one-cycle pulse when duty_o/period_o update
//   stuck_o       high while the line has shown no rise for TIMEOUT clocks
//   stuck_lvl_o   line level captured when the stuck condition was entered
//   ovr_o         one-cycle pulse when a sample is dropped (divider busy)
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int DUTY_W  = PWM_DUTY_W,
  parameter int CNT_W   = PWM_CNT_W,
  parameter int TIMEOUT = PWM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_o,
  output logic [CNT_W-1:0]  period_o,
  output logic              valid_o,
  output logic              stuck_o,
  output logic              stuck_lvl_o,
  output logic              ovr_o
);

  // [0],[1]: metastability stages, [2]: registered level s, [3]: s delayed
  logic [3:0] sync_pipe;
  logic       s;
  logic       rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[2:0], pwm_in};
  end

  assign s    = sync_pipe[2];
  assign rise = sync_pipe[2] & ~sync_pipe[3];

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic [CNT_W-1:0] samp_p;

  logic cnt_restart, cnt_inc;
  logic div_start, div_abort;
  logic ovr_d, stuck_enter, stuck_clr;

  logic              div_busy, div_done;
  logic [DUTY_W-1:0] div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_restart = 1'b0;
    cnt_inc     = 1'b0;
    div_start   = 1'b0;
    div_abort   = 1'b0;
    ovr_d       = 1'b0;
    stuck_enter = 1'b0;
    stuck_clr   = 1'b0;
    if (!ena) begin
      state_d   = IDLE;
      div_abort = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          // first rise only opens a measurement window
          if (rise) begin
            cnt_restart = 1'b1;
            state_d     = MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            cnt_restart = 1'b1;
            if (div_busy) ovr_d     = 1'b1;
            else          div_start = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            // this increment brings period_cnt to TIMEOUT; a rise takes priority
            if (period_cnt == CNT_W'(TIMEOUT - 1)) begin
              stuck_enter = 1'b1;
              div_abort   = 1'b1;
              state_d     = STUCK;
            end
          end
        end
        STUCK: begin
          if (rise) begin
            cnt_restart = 1'b1;
            stuck_clr   = 1'b1;
            state_d     = MEAS;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      samp_p     <= '0;
    end else begin
      if (!ena) begin
        period_cnt <= '0;
        high_cnt   <= '0;
      end else if (cnt_restart) begin
        // the rise cycle itself is high and belongs to the new period
        period_cnt <= CNT_W'(1);
        high_cnt   <= CNT_W'(1);
      end else if (cnt_inc) begin
        period_cnt <= period_cnt + CNT_W'(1);
        high_cnt   <= high_cnt + CNT_W'(s);
      end
      if (div_start) samp_p <= period_cnt;
    end
  end

  pwm_frac_div #(
    .DUTY_W (DUTY_W),
    .CNT_W  (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .abort (div_abort),
    .h     (high_cnt),
    .p     (period_cnt),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_o      <= '0;
      period_o    <= '0;
      valid_o     <= 1'b0;
      stuck_o     <= 1'b0;
      stuck_lvl_o <= 1'b0;
      ovr_o       <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      ovr_o   <= ovr_d;
      if (!ena) begin
        // results held; a completing division is discarded
        stuck_o <= 1'b0;
      end else if (stuck_enter) begin
        stuck_o     <= 1'b1;
        stuck_lvl_o <= s;
        duty_o      <= {DUTY_W{s}};
        period_o    <= '0;
        valid_o     <= 1'b1;
      end else begin
        if (stuck_clr) stuck_o <= 1'b0;
        if (div_done) begin
          duty_o   <= div_q;
          period_o <= samp_p;
          valid_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
module tb_pwm_duty_decoder;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int TO = 100;

  localparam int M_IDLE  = 0;
  localparam int M_ARM   = 1;
  localparam int M_MEAS  = 2;
  localparam int M_STUCK = 3;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          ena    = 1'b0;
  logic          pwm_in = 1'b0;
  logic [DW-1:0] duty_o;
  logic [CW-1:0] period_o;
  logic          valid_o, stuck_o, stuck_lvl_o, ovr_o;

  always #5 clk = ~clk;

  pwm_duty_decoder #(
    .DUTY_W  (DW),
    .CNT_W   (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .pwm_in      (pwm_in),
    .duty_o      (duty_o),
    .period_o    (period_o),
    .valid_o     (valid_o),
    .stuck_o     (stuck_o),
    .stuck_lvl_o (stuck_lvl_o),
    .ovr_o       (ovr_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pin history: newest sample at [0]; the level seen by the measurer is
  // the pin three clocks back, its predecessor four clocks back
  logic [3:0] dly;
  int         m_st, pc, hc, ecyc;
  bit         pend;
  int         pend_at, pend_duty, pend_per;
  int         e_duty, e_per;
  bit         e_vld, e_stk, e_lvl, e_ovr;
  int         ovr_seen, vld_seen;

  function automatic void model_reset();
    dly   = '0;
    m_st  = M_IDLE;
    pc    = 0;
    hc    = 0;
    pend  = 0;
    e_duty = 0; e_per = 0;
    e_vld = 0; e_stk = 0; e_lvl = 0; e_ovr = 0;
  endfunction

  function automatic void model_edge();
    logic lvl, rs;
    bit   busy;
    ecyc++;
    lvl = dly[2];
    rs  = dly[2] & ~dly[3];
    dly = {dly[2:0], pwm_in};
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_vld = 0;
    e_ovr = 0;
    if (!ena) begin
      m_st = M_IDLE; pend = 0; e_stk = 0; pc = 0; hc = 0;
      return;
    end
    busy = pend;
    if (pend && ecyc == pend_at) begin
      e_vld = 1; e_duty = pend_duty; e_per = pend_per; pend = 0;
    end
    case (m_st)
      M_IDLE: m_st = M_ARM;
      M_ARM: if (rs) begin pc = 1; hc = 1; m_st = M_MEAS; end
      M_MEAS: begin
        if (rs) begin
          if (busy) e_ovr = 1;
          else begin
            pend      = 1;
            pend_at   = ecyc + DW + 1;
            pend_duty = int'((longint'(hc) << DW) / longint'(pc));
            pend_per  = pc;
          end
          pc = 1; hc = 1;
        end else begin
          pc++;
          hc += int'(lvl);
          if (pc == TO) begin
            m_st = M_STUCK; e_stk = 1; e_lvl = lvl;
            e_duty = lvl ? (1 << DW) - 1 : 0;
            e_per = 0; e_vld = 1; pend = 0;
          end
        end
      end
      default: if (rs) begin e_stk = 0; pc = 1; hc = 1; m_st = M_MEAS; end
    endcase
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".valid"},  32'(valid_o),     32'(e_vld));
    chk({tag, ".ovr"},    32'(ovr_o),       32'(e_ovr));
    chk({tag, ".stuck"},  32'(stuck_o),     32'(e_stk));
    chk({tag, ".lvl"},    32'(stuck_lvl_o), 32'(e_lvl));
    chk({tag, ".duty"},   32'(duty_o),      32'(e_duty));
    chk({tag, ".period"}, 32'(period_o),    32'(e_per));
  endtask

  // one clock: update the model for this edge, compare, then drive the pin
  task automatic tick(input logic pin);
    @(posedge clk);
    model_edge();
    #1;
    check_outs("cyc");
    if (ovr_o)   ovr_seen++;
    if (valid_o) vld_seen++;
    pwm_in = pin;
  endtask

  task automatic run(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < hi; j++) tick(1'b1);
      for (int j = 0; j < lo; j++) tick(1'b0);
    end
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("arst");
    for (int j = 0; j < 3; j++) tick(1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    ecyc = 0; ovr_seen = 0; vld_seen = 0;
    model_reset();
    for (int j = 0; j < 4; j++) tick(1'b0);
    check_outs("reset");
    rst_n = 1'b1;
    ena   = 1'b1;

    run(3, 5, 6);
    chk("p8.duty", 32'(duty_o), 32'd96);
    chk("p8.per",  32'(period_o), 32'd8);

    run(8, 8, 4);
    chk("p16.duty", 32'(duty_o), 32'd128);
    chk("p16.per",  32'(period_o), 32'd16);

    run(1, 15, 4);
    chk("p16n.duty", 32'(duty_o), 32'd16);

    ovr_seen = 0;
    run(2, 3, 8);
    chk("p5.duty", 32'(duty_o), 32'd102);
    chk("p5.per",  32'(period_o), 32'd5);
    chk("p5.ovr_seen", 32'(ovr_seen > 0), 32'd1);

    // stuck low: one rise then hold low past the timeout
    vld_seen = 0;
    tick(1'b1);
    for (int j = 0; j < 115; j++) tick(1'b0);
    chk("stk_lo.stuck", 32'(stuck_o), 32'd1);
    chk("stk_lo.lvl",   32'(stuck_lvl_o), 32'd0);
    chk("stk_lo.duty",  32'(duty_o), 32'd0);
    // rise clears stuck, then hold high past the timeout
    for (int j = 0; j < 115; j++) tick(1'b1);
    chk("stk_hi.stuck", 32'(stuck_o), 32'd1);
    chk("stk_hi.lvl",   32'(stuck_lvl_o), 32'd1);
    chk("stk_hi.duty",  32'(duty_o), 32'd255);
    for (int j = 0; j < 3; j++) tick(1'b0);
    for (int j = 0; j < 6; j++) tick(1'b1);
    chk("stk_clr.stuck", 32'(stuck_o), 32'd0);
    run(3, 7, 3);

    // enable dropped while a division is in flight
    run(4, 6, 3);
    tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
    ena = 1'b0;
    for (int j = 0; j < 6; j++) tick(1'b0);
    chk("ena_off.stuck", 32'(stuck_o), 32'd0);
    ena = 1'b1;
    run(4, 6, 4);

    // reset in the middle of a division
    run(5, 5, 2);
    tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b0);
    async_reset();
    run(6, 4, 4);

    for (int i = 0; i < 40; i++) begin
      run($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 4));
      if ($urandom_range(0, 6) == 0) begin
        ena = 1'b0;
        for (int j = 0; j < int'($urandom_range(1, 6)); j++) tick(1'($urandom_range(0, 1)));
        ena = 1'b1;
      end
      if ($urandom_range(0, 12) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
